// File: rtl/soc2_sysid_pkg.sv
// Shared types and constants for the SoC2 system-ID boot checker.
// Holds the check FSM state encoding and the Avalon word addresses of the ID slave.
package soc2_sysid_pkg;

   localparam int unsigned SYSID_DATA_W = 32;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RD_ID_REQ  = 3'd1,
      ST_RD_ID_WAIT = 3'd2,
      ST_RD_TS_REQ  = 3'd3,
      ST_RD_TS_WAIT = 3'd4,
      ST_DONE       = 3'd5
   } sysid_state_e;

   function automatic logic sysid_is_busy(input sysid_state_e s);
      return (s == ST_RD_ID_REQ) || (s == ST_RD_ID_WAIT) ||
             (s == ST_RD_TS_REQ) || (s == ST_RD_TS_WAIT);
   endfunction

   function automatic logic sysid_is_req(input sysid_state_e s);
      return (s == ST_RD_ID_REQ) || (s == ST_RD_TS_REQ);
   endfunction

endpackage

// File: rtl/soc2_sysid_phase_timer.sv
// Per-read-phase watchdog: synchronous clear, counts while enabled, saturates.
// expired is high on the last permitted cycle of a phase of LIMIT cycles.
module soc2_sysid_phase_timer #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q equals the number of cycles already spent in the phase
   assign expired = en && (count_q >= CNT_LAST);

endmodule

// File: rtl/soc2_sysid_checker.sv
// Avalon-MM master that reads the SoC2 system-ID word and build timestamp,
// then reports whether the ID matches EXPECTED_ID (or that a read timed out).
module soc2_sysid_checker
   import soc2_sysid_pkg::*;
#(
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = 32'h0000_0000,
   parameter int unsigned             TIMEOUT_CYCLES = 255,
   parameter bit                      AUTO_START     = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   output logic                    avm_address,
   output logic                    avm_read,
   input  logic [SYSID_DATA_W-1:0] avm_readdata,
   input  logic                    avm_waitrequest,
   input  logic                    avm_readdatavalid,
   output logic                    busy,
   output logic                    done,
   output logic                    id_ok,
   output logic                    timeout,
   output logic [SYSID_DATA_W-1:0] sysid_value,
   output logic [SYSID_DATA_W-1:0] timestamp_value
);

   sysid_state_e state_q, state_d;
   logic auto_pend_q, auto_pend_d;
   logic avm_read_q, avm_read_d;
   logic avm_address_q, avm_address_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic id_ok_q, id_ok_d;
   logic timeout_q, timeout_d;
   logic [SYSID_DATA_W-1:0] sysid_q, sysid_d;
   logic [SYSID_DATA_W-1:0] ts_q, ts_d;

   logic accept;
   logic phase_clr;
   logic phase_en;
   logic phase_expired;

   soc2_sysid_phase_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_phase_timer (
      .clk     (clock),
      .rst_n   (reset_n),
      .clr     (phase_clr),
      .en      (phase_en),
      .expired (phase_expired)
   );

   always_comb begin
      state_d     = state_q;
      auto_pend_d = auto_pend_q;
      id_ok_d     = id_ok_q;
      timeout_d   = timeout_q;
      sysid_d     = sysid_q;
      ts_d        = ts_q;
      accept      = avm_read_q && !avm_waitrequest;

      // A capture on the last permitted cycle wins over the timeout.
      unique case (state_q)
         ST_IDLE: begin
            if (start || auto_pend_q) begin
               state_d     = ST_RD_ID_REQ;
               auto_pend_d = 1'b0;
               id_ok_d     = 1'b0;
               timeout_d   = 1'b0;
            end
         end
         ST_RD_ID_REQ: begin
            if (accept && avm_readdatavalid) begin
               sysid_d = avm_readdata;
               state_d = ST_RD_TS_REQ;
            end else if (phase_expired) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end else if (accept) begin
               state_d = ST_RD_ID_WAIT;
            end
         end
         ST_RD_ID_WAIT: begin
            if (avm_readdatavalid) begin
               sysid_d = avm_readdata;
               state_d = ST_RD_TS_REQ;
            end else if (phase_expired) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         ST_RD_TS_REQ: begin
            if (accept && avm_readdatavalid) begin
               ts_d    = avm_readdata;
               state_d = ST_DONE;
               id_ok_d = (sysid_q == EXPECTED_ID) && !timeout_q;
            end else if (phase_expired) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end else if (accept) begin
               state_d = ST_RD_TS_WAIT;
            end
         end
         ST_RD_TS_WAIT: begin
            if (avm_readdatavalid) begin
               ts_d    = avm_readdata;
               state_d = ST_DONE;
               id_ok_d = (sysid_q == EXPECTED_ID) && !timeout_q;
            end else if (phase_expired) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_d   = ST_RD_ID_REQ;
               id_ok_d   = 1'b0;
               timeout_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered images of the next state.
      avm_read_d    = sysid_is_req(state_d);
      avm_address_d = ((state_d == ST_RD_TS_REQ) || (state_d == ST_RD_TS_WAIT)) ?
                      SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy_d        = sysid_is_busy(state_d);
      done_d        = (state_d == ST_DONE);

      phase_clr = sysid_is_req(state_d) && (state_d != state_q);
      phase_en  = sysid_is_busy(state_q);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         auto_pend_q   <= AUTO_START;
         avm_read_q    <= 1'b0;
         avm_address_q <= SYSID_ADDR_ID;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         timeout_q     <= 1'b0;
         sysid_q       <= '0;
         ts_q          <= '0;
      end else begin
         state_q       <= state_d;
         auto_pend_q   <= auto_pend_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         id_ok_q       <= id_ok_d;
         timeout_q     <= timeout_d;
         sysid_q       <= sysid_d;
         ts_q          <= ts_d;
      end
   end

   assign avm_address     = avm_address_q;
   assign avm_read        = avm_read_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign id_ok           = id_ok_q;
   assign timeout         = timeout_q;
   assign sysid_value     = sysid_q;
   assign timestamp_value = ts_q;

endmodule

// File: tb/tb_soc2_sysid_checker.sv
// Self-checking bench: configurable Avalon slave plus a per-check outcome model
// derived from per-phase stall/latency counts.
module tb_soc2_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam int unsigned T      = 10;
   localparam logic [31:0] TS0    = 32'h6723_5AD9;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;
   logic        busy, done, id_ok, timeout;
   logic [31:0] sysid_value, timestamp_value;

   soc2_sysid_checker #(
      .EXPECTED_ID    (EXP_ID),
      .TIMEOUT_CYCLES (T),
      .AUTO_START     (1'b1)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_readdata      (avm_readdata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid),
      .busy              (busy),
      .done              (done),
      .id_ok             (id_ok),
      .timeout           (timeout),
      .sysid_value       (sysid_value),
      .timestamp_value   (timestamp_value)
   );

   always #5 clock = ~clock;

   // Slave behaviour: per address, stall cfg_w cycles, then return data cfg_l cycles after accept.
   int unsigned cfg_w [2];
   int unsigned cfg_l [2];
   logic [31:0] cfg_data [2];
   logic        stray_valid = 1'b0;
   int unsigned stall_cnt, lat_cnt;
   logic        pend, pend_addr;

   always_comb begin
      avm_waitrequest   = avm_read && (stall_cnt < cfg_w[avm_address]);
      avm_readdatavalid = stray_valid ||
                          (avm_read && !avm_waitrequest && (cfg_l[avm_address] == 0)) ||
                          (pend && (lat_cnt == cfg_l[pend_addr]));
      avm_readdata      = pend ? cfg_data[pend_addr] : cfg_data[avm_address];
      if (stray_valid) avm_readdata = 32'hDEAD_BEEF;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= 0;
         lat_cnt   <= 0;
         pend      <= 1'b0;
         pend_addr <= 1'b0;
      end else begin
         if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
         else                             stall_cnt <= 0;
         if (pend) begin
            if (lat_cnt == cfg_l[pend_addr]) pend <= 1'b0;
            else                             lat_cnt <= lat_cnt + 1;
         end
         if (avm_read && !avm_waitrequest && (cfg_l[avm_address] != 0)) begin
            pend      <= 1'b1;
            pend_addr <= avm_address;
            lat_cnt   <= 1;
         end
      end
   end

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [31:0] m_sysid = '0;
   logic [31:0] m_ts    = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic set_cfg(input int unsigned wid, input int unsigned lid,
                          input int unsigned wts, input int unsigned lts,
                          input logic [31:0] id, input logic [31:0] ts);
      cfg_w[0] = wid; cfg_l[0] = lid; cfg_data[0] = id;
      cfg_w[1] = wts; cfg_l[1] = lts; cfg_data[1] = ts;
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_read"},  32'(avm_read), 0);
      chk({pfx, "_addr"},  32'(avm_address), 0);
      chk({pfx, "_busy"},  32'(busy), 0);
      chk({pfx, "_done"},  32'(done), 0);
      chk({pfx, "_idok"},  32'(id_ok), 0);
      chk({pfx, "_tmo"},   32'(timeout), 0);
      chk({pfx, "_sysid"}, sysid_value, 0);
      chk({pfx, "_ts"},    timestamp_value, 0);
   endtask

   // Caller is positioned 1 time unit after the edge that starts cycle 0.
   task automatic run_check(input bit kick, input bit poke);
      int unsigned id_c, ts_c, len_id, len_ts, exp_done, exp_idr, exp_tsr;
      int unsigned n, idr, tsr;
      bit id_to, ts_to, seen;
      logic [31:0] e_sysid, e_ts;
      id_c   = cfg_w[0] + cfg_l[0];
      ts_c   = cfg_w[1] + cfg_l[1];
      id_to  = (id_c >= T);
      ts_to  = !id_to && (ts_c >= T);
      len_id = id_to ? T : id_c + 1;
      len_ts = ts_to ? T : ts_c + 1;
      exp_done = 1 + len_id + (id_to ? 0 : len_ts);
      exp_idr  = (cfg_w[0] + 1 < T) ? cfg_w[0] + 1 : T;
      exp_tsr  = id_to ? 0 : ((cfg_w[1] + 1 < T) ? cfg_w[1] + 1 : T);
      e_sysid  = id_to ? m_sysid : cfg_data[0];
      e_ts     = (id_to || ts_to) ? m_ts : cfg_data[1];
      if (kick) start = 1'b1;
      idr = 0; tsr = 0; seen = 0; n = 0;
      while (!seen && n < 100) begin
         @(posedge clock); #1;
         n++;
         start = poke && (n == 2 || n == exp_done - 1);
         if (n == 1) chk("busy_c1", 32'(busy), 1);
         if (avm_read && avm_address == 1'b0) idr++;
         if (avm_read && avm_address == 1'b1) tsr++;
         seen = done;
      end
      start = 1'b0;
      chk("done_seen",  32'(seen), 1);
      chk("done_cycle", 32'(n), 32'(exp_done));
      chk("id_reads",   32'(idr), 32'(exp_idr));
      chk("ts_reads",   32'(tsr), 32'(exp_tsr));
      chk("timeout",    32'(timeout), 32'(id_to || ts_to));
      chk("id_ok",      32'(id_ok), 32'(!(id_to || ts_to) && e_sysid == EXP_ID));
      chk("sysid",      sysid_value, e_sysid);
      chk("tstamp",     timestamp_value, e_ts);
      repeat (3) begin @(posedge clock); #1; end
      chk("done_hold",  32'({done, busy}), 32'(2'b10));
      m_sysid = e_sysid;
      m_ts    = e_ts;
   endtask

   task automatic idle(input int unsigned c);
      repeat (c) begin @(posedge clock); #1; end
   endtask

   initial begin
      set_cfg(0, 0, 0, 0, 32'h0, TS0);
      repeat (3) @(posedge clock);
      #1;
      chk_reset_vals("rst");

      // Auto-started check after reset release, zero-wait slave.
      reset_n = 1'b1;
      run_check(1'b0, 1'b0);
      idle(15);

      // ID mismatch.
      set_cfg(0, 0, 0, 0, 32'h0000_0001, TS0);
      run_check(1'b1, 1'b0);
      idle(15);

      // ID stalled 3 cycles, TS data 2 cycles after accept; start pokes while busy.
      set_cfg(3, 0, 0, 2, 32'h0, 32'h1234_5678);
      run_check(1'b1, 1'b1);
      idle(15);

      // Waitrequest stuck high: timeout, then stray valid must be ignored.
      set_cfg(255, 0, 0, 0, 32'hAAAA_5555, 32'h0BAD_0BAD);
      run_check(1'b1, 1'b0);
      stray_valid = 1'b1;
      idle(2);
      stray_valid = 1'b0;
      idle(1);
      chk("stray_sysid", sysid_value, m_sysid);
      chk("stray_state", 32'({done, timeout, id_ok}), 32'(3'b110));
      idle(10);

      // Restart from DONE twice; both must behave identically.
      set_cfg(0, 0, 0, 0, 32'h0, TS0);
      run_check(1'b1, 1'b0);
      idle(5);
      run_check(1'b1, 1'b0);
      idle(15);

      // Asynchronous reset while the TS read is outstanding.
      set_cfg(0, 0, 0, 6, 32'h0, 32'h5555_AAAA);
      start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(3);
      chk("pre_rst_busy", 32'(busy), 1);
      #2 reset_n = 1'b0;
      #1 chk_reset_vals("midrst");
      m_sysid = '0;
      m_ts    = '0;
      set_cfg(0, 0, 0, 0, 32'h0, TS0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      run_check(1'b0, 1'b0);
      idle(15);

      // Randomized slave timing and data.
      for (int i = 0; i < 20; i++) begin
         int unsigned wi, li, wt, lt;
         logic [31:0] id, ts;
         wi = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 14) : $urandom_range(0, 3);
         li = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 3);
         wt = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 14) : $urandom_range(0, 3);
         lt = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 3);
         id = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
         ts = $urandom;
         set_cfg(wi, li, wt, lt, id, ts);
         run_check(1'b1, $urandom_range(0, 1) == 1);
         idle(16);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/soc2_sysid_checker.md
# soc2_sysid_checker

Avalon-MM master that reads the SoC2 system-ID slave at boot (or on request), captures the ID word and the build timestamp, and flags whether the ID matches the value this software/hardware build expects. It connects to the control slave of the SoC2 system-ID peripheral through the fabric. Its status outputs gate boot logic, LEDs or a CPU-visible status register.

## Interface
- EXPECTED_ID, 32'h0000_0000, ID word that must be read from address 0 for `id_ok`
- TIMEOUT_CYCLES, 255, max cycles per read phase before abort (legal range 2..65535)
- AUTO_START, 1, if 1, one check starts automatically after reset release
- clock  in  1  sole clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to (re)run a check; ignored while `busy`
- avm_address  out  1  word address (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data valid
- busy  out  1  check in progress
- done  out  1  level, check finished (success, mismatch or timeout)
- id_ok  out  1  level, captured ID == EXPECTED_ID and no timeout
- timeout  out  1  level, a read phase exceeded TIMEOUT_CYCLES
- sysid_value  out  32  captured ID word
- timestamp_value  out  32  captured timestamp word

## Operation
- States: IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, DONE.
- IDLE: on `start` (or first cycle after reset when AUTO_START=1) -> RD_ID_REQ; clear done/id_ok/timeout.
- xx_REQ: `avm_read`=1, `avm_address` = 0 (ID) or 1 (TS), held stable until accepted (`avm_read && !avm_waitrequest`).
  - accepted with `avm_readdatavalid`=1 same cycle: capture, advance directly to next REQ (or DONE).
  - accepted without valid: -> xx_WAIT, `avm_read`=0.
- xx_WAIT: on `avm_readdatavalid` capture `avm_readdata`, advance. Max one outstanding read.
- DONE: `done`=1, `id_ok` = (sysid_value == EXPECTED_ID) && !timeout; `start` -> RD_ID_REQ (status cleared, captured values retained until overwritten).
- Timeout: phase counter cleared on entry to each REQ state, increments every cycle in REQ/WAIT; when phase has lasted TIMEOUT_CYCLES cycles without capture -> DONE, `timeout`=1, `avm_read` dropped. Counter width $clog2(TIMEOUT_CYCLES+1); saturates, no wrap.
- `avm_readdatavalid` outside WAIT/accepting-REQ cycles ignored (late data after timeout discarded).
- `busy` = state in {RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT}.

## Timing
- Reset values: avm_read 0, avm_address 0, busy 0, done 0, id_ok 0, timeout 0, sysid_value 0, timestamp_value 0, state IDLE.
- All outputs registered; no combinational path from Avalon inputs to outputs.
- Zero-wait, zero-latency slave: `start` sampled cycle 0 -> ID read cycle 1 -> TS read cycle 2 -> `done`/`id_ok` high cycle 3.
- Each waitrequest cycle or readdatavalid latency cycle adds one cycle.
- `start` coincident with DONE entry: ignored (start only honoured in IDLE/DONE state as registered).
- reset_n low mid-transaction: immediate return to reset values; outstanding read abandoned.

## Structure
- Package `soc2_sysid_pkg`: state enum, `SYSID_ADDR_ID`=1'b0, `SYSID_ADDR_TS`=1'b1, `SYSID_DATA_W`=32.
- Sub-module `soc2_sysid_phase_timer`: clear/enable saturating counter with `expired` flag; rest is a single FSM module.

## Test plan
- Zero-wait slave returning ID 0, TS 32'h6723_5AD9, AUTO_START=1 -> done at cycle 3 after reset release, id_ok=1, timestamp_value=32'h6723_5AD9.
- Slave returns ID 32'h0000_0001 -> done=1, id_ok=0, timeout=0, sysid_value=1.
- waitrequest high 3 cycles on ID read, readdatavalid 2 cycles after accept on TS -> address/read stable while stalled, done at cycle 8, id_ok=1.
- waitrequest stuck high, TIMEOUT_CYCLES=10 -> avm_read drops after 10 cycles, done=1, timeout=1, id_ok=0; later stray readdatavalid ignored.
- start pulse while busy -> ignored; start in DONE -> status cleared, second check completes identically.
- reset_n asserted during RD_TS_WAIT -> all outputs to reset values asynchronously; AUTO_START check reruns after release.
